genius_pad_renderer: RTL



---
 rtl/genius_pad_renderer_if.sv | 33 +++
 rtl/genius_pad_renderer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/genius_pad_renderer_if.sv
// Bundle between the sync generator / game logic side and the Genius pad renderer:
// raster inputs, pad-lighting handshake and the DAC-facing RGB444 + sync outputs.
interface genius_pad_renderer_if;
    logic [9:0] x_px;
    logic [9:0] y_px;
    logic       hsync_in;
    logic       vsync_in;
    logic       activevideo_in;
    logic       light_req;
    logic [1:0] light_pad;
    logic [5:0] light_frames;
    logic       light_busy;
    logic       light_done;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hsync;
    logic       vga_vsync;

    modport master (
        output x_px, y_px, hsync_in, vsync_in, activevideo_in,
        output light_req, light_pad, light_frames,
        input  light_busy, light_done,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync
    );

    modport slave (
        input  x_px, y_px, hsync_in, vsync_in, activevideo_in,
        input  light_req, light_pad, light_frames,
        output light_busy, light_done,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync
    );
endinterface

// File: rtl/genius_pad_renderer.sv
// Paints the four Genius pads as screen quadrants behind a two-stage pipeline and
// lights one pad for a whole number of frames via a request/done handshake.
module genius_pad_renderer #(
    parameter int unsigned H_DISP = 640,
    parameter int unsigned V_DISP = 480,
    parameter int unsigned GAP    = 8,
    parameter logic [3:0]  DIM    = 4'h4,
    parameter logic [3:0]  BRIGHT = 4'hF
) (
    input  logic                  px_clk,
    input  logic                  rst,
    genius_pad_renderer_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_LIT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [9:0] X_MID = 10'(H_DISP / 2);
    localparam logic [9:0] X_LO  = 10'(H_DISP / 2 - GAP / 2);
    localparam logic [9:0] X_HI  = 10'(H_DISP / 2 + GAP / 2 - 1);
    localparam logic [9:0] Y_MID = 10'(V_DISP / 2);
    localparam logic [9:0] Y_LO  = 10'(V_DISP / 2 - GAP / 2);
    localparam logic [9:0] Y_HI  = 10'(V_DISP / 2 + GAP / 2 - 1);

    logic       hs1_q, hs1_d, vs1_q, vs1_d, av1_q, av1_d;
    logic       hs2_q, hs2_d, vs2_q, vs2_d;
    logic [3:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [1:0] state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] pad_q, pad_d;
    logic       busy_q, busy_d, done_q, done_d;

    logic       frame_start_s;
    logic       in_cross_s;
    logic [1:0] quad_s;
    logic [3:0] lvl_s;

    // Stage-1 delay of vsync doubles as the edge detector: fall lands in vertical blanking.
    always_comb begin
        frame_start_s = vs1_q & ~bus.vsync_in;
    end

    // Lighting FSM; a request taken in IDLE never consumes a simultaneous frame start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pad_d   = pad_q;
        case (state_q)
            S_IDLE: begin
                if (bus.light_req) begin
                    state_d = S_WAIT;
                    pad_d   = bus.light_pad;
                    cnt_d   = (bus.light_frames == 6'd0) ? 6'd1 : bus.light_frames;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (frame_start_s) begin
                    state_d = S_LIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_LIT: begin
                if (frame_start_s) begin
                    if (cnt_q <= 6'd1) begin
                        state_d = S_DONE;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d   = cnt_q - 6'd1;
                    end
                end else begin
                    state_d = S_LIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
        busy_d = (state_d == S_WAIT) || (state_d == S_LIT);
        done_d = (state_d == S_DONE);
    end

    // Colour from stage-1 active flag and coordinates, which arrive one cycle after activevideo_in.
    always_comb begin
        hs1_d      = bus.hsync_in;
        vs1_d      = bus.vsync_in;
        av1_d      = bus.activevideo_in;
        hs2_d      = hs1_q;
        vs2_d      = vs1_q;
        in_cross_s = ((bus.x_px >= X_LO) && (bus.x_px <= X_HI)) ||
                     ((bus.y_px >= Y_LO) && (bus.y_px <= Y_HI));
        quad_s     = {(bus.y_px >= Y_MID), (bus.x_px >= X_MID)};
        lvl_s      = ((state_q == S_LIT) && (quad_s == pad_q)) ? BRIGHT : DIM;
        r_d        = 4'h0;
        g_d        = 4'h0;
        b_d        = 4'h0;
        if (av1_q && !in_cross_s) begin
            case (quad_s)
                2'd0:    g_d = lvl_s;
                2'd1:    r_d = lvl_s;
                2'd2:    begin r_d = lvl_s; g_d = lvl_s; end
                2'd3:    b_d = lvl_s;
                default: begin r_d = 4'h0; g_d = 4'h0; b_d = 4'h0; end
            endcase
        end else begin
            r_d = 4'h0;
            g_d = 4'h0;
            b_d = 4'h0;
        end
    end

    // All state and pipeline registers.
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            av1_q   <= 1'b0;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
            r_q     <= 4'h0;
            g_q     <= 4'h0;
            b_q     <= 4'h0;
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            pad_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            av1_q   <= av1_d;
            hs2_q   <= hs2_d;
            vs2_q   <= vs2_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pad_q   <= pad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.vga_r      = r_q;
    assign bus.vga_g      = g_q;
    assign bus.vga_b      = b_q;
    assign bus.vga_hsync  = hs2_q;
    assign bus.vga_vsync  = vs2_q;
    assign bus.light_busy = busy_q;
    assign bus.light_done = done_q;

endmodule
